// File: rtl/char_write_scheduler_if.sv
// Write-port bundle between the command handler (master) and the character
// write scheduler (slave), including the character-buffer write outputs.
interface char_write_scheduler_if #(
    parameter int ADDR_BITS = 11
);
    logic                 a_valid;
    logic                 a_ready;
    logic [ADDR_BITS-1:0] a_addr;
    logic [7:0]           a_char;

    logic                 fill_valid;
    logic                 fill_ready;
    logic [ADDR_BITS-1:0] fill_start;
    logic [ADDR_BITS-1:0] fill_count;
    logic [7:0]           fill_char;
    logic                 fill_done;

    logic                 busy;
    logic [7:0]           new_char;
    logic [ADDR_BITS-1:0] new_char_address;
    logic                 new_char_wen;

    modport master (
        output a_valid, a_addr, a_char,
        output fill_valid, fill_start, fill_count, fill_char,
        input  a_ready, fill_ready, fill_done, busy,
        input  new_char, new_char_address, new_char_wen
    );

    modport slave (
        input  a_valid, a_addr, a_char,
        input  fill_valid, fill_start, fill_count, fill_char,
        output a_ready, fill_ready, fill_done, busy,
        output new_char, new_char_address, new_char_wen
    );
endinterface

// File: rtl/char_write_scheduler.sv
// Merges single-cell writes and bulk fill runs onto the character-buffer write port.
// Optional macro SCHED_WRAP_ADDR_EN: fill addresses wrap at COLS*ROWS instead of 2^ADDR_BITS.
module char_write_scheduler #(
    parameter int ADDR_BITS = 11,
    parameter int COLS      = 80,
    parameter int ROWS      = 24
) (
    input logic                    clk,
    input logic                    clr,
    char_write_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

`ifdef SCHED_WRAP_ADDR_EN
    localparam logic [ADDR_BITS-1:0] LAST_CELL = ADDR_BITS'(COLS * ROWS - 1);
`endif

    // The visible screen must fit inside the addressable buffer.
    if (COLS * ROWS > (1 << ADDR_BITS)) begin : gBadGeometry
        $error("COLS*ROWS exceeds character-buffer address space");
    end

    state_t               state_q;
    logic [7:0]           fillChar_q;
    logic [ADDR_BITS-1:0] curAddr_q;
    logic [ADDR_BITS-1:0] remaining_q;
    logic [7:0]           newChar_q;
    logic [ADDR_BITS-1:0] newCharAddr_q;
    logic                 newCharWen_q;
    logic                 fillDone_q;
    logic                 busy_q;
    logic [ADDR_BITS-1:0] curAddr_d;
    logic [ADDR_BITS-1:0] startAddr_d;

    function automatic logic [ADDR_BITS-1:0] nextAddr(input logic [ADDR_BITS-1:0] a);
`ifdef SCHED_WRAP_ADDR_EN
        if (a == LAST_CELL) begin
            return '0;
        end
`endif
        return a + ADDR_BITS'(1);
    endfunction

    assign curAddr_d   = nextAddr(curAddr_q);
    assign startAddr_d = nextAddr(bus.fill_start);

    assign bus.a_ready          = clr && (state_q == IDLE);
    assign bus.fill_ready       = clr && (state_q == IDLE) && !bus.a_valid;
    assign bus.fill_done        = fillDone_q;
    assign bus.busy             = busy_q;
    assign bus.new_char         = newChar_q;
    assign bus.new_char_address = newCharAddr_q;
    assign bus.new_char_wen     = newCharWen_q;

    // The first fill cell is issued on the accept edge, so the count kept
    // afterwards is the number of cells still owed after the one on the bus.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q       <= IDLE;
            fillChar_q    <= '0;
            curAddr_q     <= '0;
            remaining_q   <= '0;
            newChar_q     <= '0;
            newCharAddr_q <= '0;
            newCharWen_q  <= 1'b0;
            fillDone_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            newCharWen_q <= 1'b0;
            fillDone_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.a_valid) begin
                        newChar_q     <= bus.a_char;
                        newCharAddr_q <= bus.a_addr;
                        newCharWen_q  <= 1'b1;
                    end else if (bus.fill_valid) begin
                        fillChar_q <= bus.fill_char;
                        busy_q     <= 1'b1;
                        if (bus.fill_count == '0) begin
                            state_q    <= DONE;
                            fillDone_q <= 1'b1;
                        end else begin
                            state_q       <= FILL;
                            newChar_q     <= bus.fill_char;
                            newCharAddr_q <= bus.fill_start;
                            newCharWen_q  <= 1'b1;
                            curAddr_q     <= startAddr_d;
                            remaining_q   <= bus.fill_count - ADDR_BITS'(1);
                        end
                    end
                end
                FILL: begin
                    if (remaining_q == '0) begin
                        state_q    <= DONE;
                        fillDone_q <= 1'b1;
                    end else begin
                        newChar_q     <= fillChar_q;
                        newCharAddr_q <= curAddr_q;
                        newCharWen_q  <= 1'b1;
                        curAddr_q     <= curAddr_d;
                        remaining_q   <= remaining_q - ADDR_BITS'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_char_write_scheduler.sv
// Scoreboard bench for char_write_scheduler: stimulus pushes expected writes and
// fill_done events, a negedge monitor pops and compares them.
module tb_char_write_scheduler;
    localparam int AB = 11;

    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    char_write_scheduler_if #(.ADDR_BITS(AB)) bus ();

    char_write_scheduler #(.ADDR_BITS(AB), .COLS(80), .ROWS(24)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    typedef struct {
        bit          isDone;
        logic [10:0] addr;
        logic [7:0]  ch;
    } exp_t;

    exp_t sb[$];
    int   checksTotal  = 0;
    int   checksPassed = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic logic [10:0] modelNext(input logic [10:0] a);
`ifdef SCHED_WRAP_ADDR_EN
        if (a == 11'd1919) return 11'd0;
`endif
        return a + 11'd1;
    endfunction

    task automatic pushWrite(input logic [10:0] addr, input logic [7:0] ch);
        exp_t e;
        e.isDone = 1'b0;
        e.addr   = addr;
        e.ch     = ch;
        sb.push_back(e);
    endtask

    task automatic pushDone();
        exp_t e;
        e.isDone = 1'b1;
        e.addr   = '0;
        e.ch     = '0;
        sb.push_back(e);
    endtask

    task automatic pushFill(input logic [10:0] start, input int count, input logic [7:0] ch);
        logic [10:0] a;
        a = start;
        for (int i = 0; i < count; i++) begin
            pushWrite(a, ch);
            a = modelNext(a);
        end
        pushDone();
    endtask

    task automatic applyStimulus(input bit av, input logic [10:0] aa, input logic [7:0] ac,
                                 input bit fv, input logic [10:0] fs, input logic [10:0] fc,
                                 input logic [7:0] fch);
        bus.a_valid    = av;
        bus.a_addr     = aa;
        bus.a_char     = ac;
        bus.fill_valid = fv;
        bus.fill_start = fs;
        bus.fill_count = fc;
        bus.fill_char  = fch;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (!bus.a_ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("wait_idle", 32'(bus.a_ready), 32'd1);
    endtask

    // Monitor: every write or fill_done the DUT presents must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.new_char_wen || bus.fill_done) begin
                if (sb.size() == 0) begin
                    checksTotal++;
                    $display("[TB] FAIL unexpected_output: got wen=%0b done=%0b addr=0x%0h char=0x%0h, expected no output",
                             bus.new_char_wen, bus.fill_done, bus.new_char_address, bus.new_char);
                end else begin
                    e = sb.pop_front();
                    if (e.isDone)
                        checkOutput("sb_fill_done", {30'd0, bus.new_char_wen, bus.fill_done}, 32'h1);
                    else
                        checkOutput("sb_write",
                                    {11'd0, bus.new_char_wen, bus.fill_done, bus.new_char_address, bus.new_char},
                                    {11'd0, 2'b10, e.addr, e.ch});
                end
            end
        end
    end

    initial begin
        int k;
        int doneCycle;

        $display("[TB] reset with a_valid held high");
        clr = 1'b0;
        applyStimulus(1'b1, 11'h055, 8'h99, 1'b0, 11'd0, 11'd0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_wen",        32'(bus.new_char_wen),     32'd0);
        checkOutput("rst_addr",       32'(bus.new_char_address), 32'd0);
        checkOutput("rst_char",       32'(bus.new_char),         32'd0);
        checkOutput("rst_fill_done",  32'(bus.fill_done),        32'd0);
        checkOutput("rst_busy",       32'(bus.busy),             32'd0);
        checkOutput("rst_a_ready",    32'(bus.a_ready),          32'd0);
        checkOutput("rst_fill_ready", 32'(bus.fill_ready),       32'd0);
        pushWrite(11'h055, 8'h99);
        clr = 1'b1;
        #1;
        checkOutput("a_ready_after_release", 32'(bus.a_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.a_valid = 1'b0;
        checkOutput("post_reset_write_wen", 32'(bus.new_char_wen), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("post_reset_write_wen_low", 32'(bus.new_char_wen), 32'd0);

        $display("[TB] back-to-back single writes");
        applyStimulus(1'b1, 11'h123, 8'h41, 1'b0, 11'd0, 11'd0, 8'h00);
        pushWrite(11'h123, 8'h41);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 11'h124, 8'h42, 1'b0, 11'd0, 11'd0, 8'h00);
        pushWrite(11'h124, 8'h42);
        checkOutput("b2b_first_addr", 32'(bus.new_char_address), 32'h123);
        checkOutput("b2b_busy1",      32'(bus.busy),             32'd0);
        @(posedge clk);
        #1;
        bus.a_valid = 1'b0;
        checkOutput("b2b_second_wen",  32'(bus.new_char_wen),     32'd1);
        checkOutput("b2b_second_addr", 32'(bus.new_char_address), 32'h124);
        checkOutput("b2b_busy2",       32'(bus.busy),             32'd0);
        @(posedge clk);
        #1;
        checkOutput("b2b_wen_drop", 32'(bus.new_char_wen), 32'd0);

        $display("[TB] line fill with a pending single write");
        applyStimulus(1'b0, 11'd0, 8'h00, 1'b1, 11'd0, 11'd80, 8'h20);
        pushFill(11'd0, 80, 8'h20);
        #1;
        checkOutput("line_fill_ready", 32'(bus.fill_ready), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 11'h300, 8'h7e, 1'b0, 11'd0, 11'd0, 8'h00);
        pushWrite(11'h300, 8'h7e);
        checkOutput("line_busy", 32'(bus.busy), 32'd1);
        k = 1;
        doneCycle = 0;
        while (!bus.a_ready && k < 200) begin
            if (bus.fill_done) doneCycle = k;
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("line_done_cycle",   32'(doneCycle), 32'd81);
        checkOutput("line_accept_cycle", 32'(k),         32'd82);
        @(posedge clk);
        #1;
        bus.a_valid = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] fill across the buffer end");
        applyStimulus(1'b0, 11'd0, 8'h00, 1'b1, 11'd1910, 11'd20, 8'h2e);
        for (int i = 0; i < 20; i++) begin
`ifdef SCHED_WRAP_ADDR_EN
            pushWrite(11'((1910 + i) % 1920), 8'h2e);
`else
            pushWrite(11'(1910 + i), 8'h2e);
`endif
        end
        pushDone();
        @(posedge clk);
        #1;
        bus.fill_valid = 1'b0;
        waitIdle();

        $display("[TB] simultaneous single write and fill");
        applyStimulus(1'b1, 11'h010, 8'h33, 1'b1, 11'd100, 11'd3, 8'h2d);
        pushWrite(11'h010, 8'h33);
        pushFill(11'd100, 3, 8'h2d);
        #1;
        checkOutput("sim_a_ready",    32'(bus.a_ready),    32'd1);
        checkOutput("sim_fill_ready", 32'(bus.fill_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.a_valid = 1'b0;
        #1;
        checkOutput("sim_fill_ready_after", 32'(bus.fill_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.fill_valid = 1'b0;
        checkOutput("sim_fill_first_addr", 32'(bus.new_char_address), 32'd100);
        waitIdle();

        $display("[TB] zero-count fill");
        applyStimulus(1'b0, 11'd0, 8'h00, 1'b1, 11'd5, 11'd0, 8'h11);
        pushDone();
        @(posedge clk);
        #1;
        bus.fill_valid = 1'b0;
        checkOutput("zero_done", 32'(bus.fill_done),    32'd1);
        checkOutput("zero_wen",  32'(bus.new_char_wen), 32'd0);
        checkOutput("zero_busy", 32'(bus.busy),         32'd1);
        @(posedge clk);
        #1;
        checkOutput("zero_done_drop", 32'(bus.fill_done), 32'd0);
        checkOutput("zero_idle",      32'(bus.a_ready),   32'd1);

        $display("[TB] reset during the 40th fill write");
        applyStimulus(1'b0, 11'd0, 8'h00, 1'b1, 11'd200, 11'd80, 8'h58);
        for (int i = 0; i < 39; i++) pushWrite(11'(200 + i), 8'h58);
        @(posedge clk);
        #1;
        bus.fill_valid = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        checkOutput("abort_40th_addr", 32'(bus.new_char_address), 32'd239);
        clr = 1'b0;
        #1;
        checkOutput("abort_wen_async",  32'(bus.new_char_wen), 32'd0);
        checkOutput("abort_busy_async", 32'(bus.busy),         32'd0);
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("abort_idle_after", 32'(bus.a_ready), 32'd1);
        checkOutput("abort_busy_after", 32'(bus.busy),    32'd0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end
endmodule

// File: doc/char_write_scheduler.md
# char_write_scheduler

Sequencer and arbiter for the character-buffer write port. Sits between the command handler and the character generator and owns `new_char`, `new_char_address`, `new_char_wen`. It merges single-cell writes with bulk fill runs such as clear screen, erase to end of line and blanking a scrolled-in line. Fills run one cell per clock with circular address wrap, so the command handler no longer needs its own erase loop.

## Interface

- `ADDR_BITS`, 11, width of character-buffer address.
- `COLS`, 80, characters per row.
- `ROWS`, 24, rows on screen; `BUF_SIZE = COLS*ROWS` (1920).
- `clk`  in  1  pixel-domain clock; all state changes on rising edge.
- `clr`  in  1  reset, asynchronous, active-low.
- `a_valid`  in  1  single-write request.
- `a_ready`  out  1  single write accepted when `a_valid && a_ready`.
- `a_addr`  in  ADDR_BITS  single-write address.
- `a_char`  in  8  single-write character code.
- `fill_valid`  in  1  fill request.
- `fill_ready`  out  1  fill accepted when `fill_valid && fill_ready`.
- `fill_start`  in  ADDR_BITS  first cell of fill.
- `fill_count`  in  ADDR_BITS  number of cells, 0..2047.
- `fill_char`  in  8  character written to every cell.
- `fill_done`  out  1  one-cycle pulse on fill completion.
- `busy`  out  1  high whenever state is not IDLE.
- `new_char`  out  8  character-buffer write data, registered.
- `new_char_address`  out  ADDR_BITS  character-buffer write address, registered.
- `new_char_wen`  out  1  character-buffer write enable, registered.

## Operation

- **States:** IDLE, FILL, DONE.
- **Reset values:** state IDLE; `new_char`=0, `new_char_address`=0, `new_char_wen`=0, `fill_done`=0, `busy`=0. `a_ready` and `fill_ready` are forced low while `clr` is low.
- **Ready signals:**
  - `a_ready` = (state==IDLE).
  - `fill_ready` = (state==IDLE) && !`a_valid`.
  - Single writes have fixed priority on a simultaneous request. The fill stays pending and is accepted on a later IDLE cycle.
- **IDLE, single write accepted:** register `a_addr` and `a_char` onto the write outputs with `new_char_wen`=1 for exactly one cycle. State stays IDLE, so back-to-back single writes sustain one per clock.
- **IDLE, fill accepted:**
  - Latch `fill_char`, a current address of `fill_start`, and a remaining count of `fill_count`.
  - `fill_count`=0 goes straight to DONE.
  - Otherwise go to FILL.
- **FILL, each cycle:**
  - Drive the current address and the fill char with `new_char_wen`=1.
  - Advance the address by one and decrement the remaining count.
  - When the count written this cycle reaches 1, go to DONE.
  - `a_ready` stays low throughout, so writes are strictly ordered behind the fill.
- **DONE:** `fill_done`=1 and `new_char_wen`=0 for one cycle, then IDLE.
- **Address increment:** see Configuration. An increment from 2^ADDR_BITS-1 always goes to 0.
- **Reset mid-operation:** the run aborts immediately. `new_char_wen` drops asynchronously, no `fill_done` is produced, and no further cells are written.
- Requesters must hold the request fields stable while valid is high and not yet accepted.

## Timing

- **Single-write latency:** accept at edge N, then `new_char_wen` is high during cycle N+1.
- **Fill of count C>0:**
  - Accept at edge N.
  - Writes occur in cycles N+1..N+C.
  - `fill_done` is high in cycle N+C+1.
  - IDLE (`a_ready`=1) in cycle N+C+2.
- **Fill of count 0:** `fill_done` is high in cycle N+1 with no writes.
- **Throughput:** one cell per clock, with no bubbles inside a fill.
- **Outputs:** `busy` is registered from state and is high in cycles N+1 through the DONE cycle.

## Configuration

- **`SCHED_WRAP_ADDR_EN` defined:** the fill address wraps from BUF_SIZE-1 to 0, following the circular scrolled buffer. A start at or above BUF_SIZE increments plainly until it hits 2^ADDR_BITS-1, then goes to 0.
- **Not defined:** the address increments modulo 2^ADDR_BITS only. The BUF_SIZE comparator is not built.

## Test plan

- **Reset:** hold `clr`=0 with `a_valid`=1.
  - Required: all outputs 0, `a_ready`=0.
  - After releasing `clr`, `a_ready`=1 on the next cycle, and the write completes one cycle after acceptance.
- **Single writes:** issue `a_addr`=0x123, `a_char`=0x41, then `a_addr`=0x124, `a_char`=0x42 on consecutive cycles.
  - Required: `new_char_wen` high for two consecutive cycles with those address/data pairs, and `busy`=0 throughout.
- **Fill of a line:** `fill_start`=0, `fill_count`=80, `fill_char`=0x20.
  - Required: 80 contiguous write cycles at addresses 0..79, `fill_done` in cycle 81 after accept.
  - A single write held pending meanwhile is accepted only in cycle 82.
- **Wrap:** `fill_start`=1910, `fill_count`=20.
  - With `SCHED_WRAP_ADDR_EN`: addresses 1910..1919, then 0..9.
  - Without it: addresses 1910..1929.
- **Simultaneous request:** raise `a_valid` and `fill_valid` in the same IDLE cycle.
  - Required: the single write is accepted first and `fill_ready` stays low that cycle.
  - The fill is accepted the cycle after `a_valid` drops.
- **Abort and zero count:**
  - Assert `clr` during the 40th fill write: `new_char_wen` goes low immediately, and there is no `fill_done` after release.
  - Issue `fill_count`=0: no writes, `fill_done` one cycle after accept.
